// File: rtl/align_pkg.sv
// Shared constants and lane/word/select types for the byte-lane aligner.
// Parity output enabled by defining ALIGN_PARITY_EN.
package align_pkg;
    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int SEL_LW = $clog2(LANES);
    localparam int DATA_W = LANES * LANE_W;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [LANES-1:0] word_t;
    // sel_t[i] is the source-lane field for output lane i (sel[i*SEL_LW +: SEL_LW])
    typedef logic [LANES-1:0][SEL_LW-1:0] sel_t;

    function automatic logic lane_parity(input lane_t l);
        return ^l;
    endfunction
endpackage

// File: rtl/align_lane_mux.sv
// One LANES:1 byte-lane multiplexer: picks a single input lane for one output lane.
// Purely combinational; the top owns all registers.
module align_lane_mux
    import align_pkg::*;
(
    input  word_t             i_word,
    input  logic [SEL_LW-1:0] i_sel,
    output lane_t             o_lane
);
    assign o_lane = i_word[i_sel];
endmodule

// File: rtl/align_unit.sv
// Registered byte-lane crossbar: each output lane selects any input lane, 1-cycle latency.
// Optional per-lane even parity output when ALIGN_PARITY_EN is defined.
module align_unit
    import align_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [DATA_W-1:0]       value_i,
    input  logic [LANES*SEL_LW-1:0] sel,
    output logic                    valid_o,
    output logic [DATA_W-1:0]       value_o
`ifdef ALIGN_PARITY_EN
    ,
    output logic [LANES-1:0]        parity_o
`endif
);
    word_t w_word;
    sel_t  w_sel;
    word_t w_mux;
    logic  r_valid;
    word_t r_value;

    assign w_word = value_i;
    assign w_sel  = sel;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        align_lane_mux u_mux (
            .i_word (w_word),
            .i_sel  (w_sel[g]),
            .o_lane (w_mux[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_value <= '0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_value <= w_mux;
            end
        end
    end

    assign valid_o = r_valid;
    assign value_o = r_value;

`ifdef ALIGN_PARITY_EN
    logic [LANES-1:0] w_par;
    logic [LANES-1:0] r_parity;

    always_comb begin
        w_par = '0;
        for (int i = 0; i < LANES; i++) begin
            w_par[i] = lane_parity(w_mux[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= '0;
        end else if (valid_i) begin
            r_parity <= w_par;
        end
    end

    assign parity_o = r_parity;
`endif
endmodule

// File: tb/tb_align_unit.sv
// Self-checking bench for align_unit: scoreboard queue of expected words,
// spec example vectors, back-to-back streaming and asynchronous reset.
module tb_align_unit;
    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [31:0] value_i;
    logic [7:0]  sel;
    logic        valid_o;
    logic [31:0] value_o;
`ifdef ALIGN_PARITY_EN
    logic [3:0]  parity_o;
`endif

    int errors = 0;
    int checks = 0;

    logic [35:0] q[$];
    logic [35:0] exp_e;
    logic [35:0] last_e;

    align_unit dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .value_i (value_i),
        .sel     (sel),
        .valid_o (valid_o),
        .value_o (value_o)
`ifdef ALIGN_PARITY_EN
        ,
        .parity_o(parity_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] v, input logic [7:0] s);
        logic [31:0] r;
        int src;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            src = int'(s[i*2 +: 2]);
            r[i*8 +: 8] = v[src*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [3:0] par(input logic [31:0] w);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ^w[i*8 +: 8];
        return p;
    endfunction

    // Drive one cycle of stimulus; returns at posedge+1 with outputs settled.
    task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] s);
        logic [31:0] m;
        valid_i = v;
        value_i = d;
        sel     = s;
        if (v) begin
            m = model(d, s);
            q.push_back({par(m), m});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp();
        if (q.size() == 0) begin
            exp_e = 36'hx;
        end else begin
            exp_e  = q.pop_front();
            last_e = exp_e;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; value_i = '0; sel = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b exp=0", valid_o);
        end
        checks++;
        if (value_o !== 32'h0) begin
            errors++; $display("FAIL reset_value got=%h exp=00000000", value_o);
        end
`ifdef ALIGN_PARITY_EN
        checks++;
        if (parity_o !== 4'b0) begin
            errors++; $display("FAIL reset_parity got=%b exp=0000", parity_o);
        end
`endif
        last_e = '0;
    endtask

    task automatic test_zero();
        drive(1'b1, 32'h0, 8'h00);
        pop_exp();
        checks++;
        if (valid_o !== 1'b1) begin
            errors++; $display("FAIL zero_valid got=%b exp=1", valid_o);
        end
        checks++;
        if (value_o !== 32'h0 || value_o !== exp_e[31:0]) begin
            errors++; $display("FAIL zero_value got=%h exp=00000000", value_o);
        end
    endtask

    task automatic test_mapping();
        logic [7:0]  sels [5];
        logic [31:0] exps [5];
        sels = '{8'h55, 8'h33, 8'h88, 8'hE4, 8'h1B};
        exps = '{32'h56565656, 32'h78127812, 32'h34783478,
                 32'h12345678, 32'h78563412};
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h12345678, sels[k]);
            pop_exp();
            checks++;
            if (valid_o !== 1'b1 || value_o !== exps[k] || value_o !== exp_e[31:0]) begin
                errors++;
                $display("FAIL map_sel_%h got=%b/%h exp=1/%h", sels[k], valid_o, value_o, exps[k]);
            end
`ifdef ALIGN_PARITY_EN
            checks++;
            if (parity_o !== exp_e[35:32]) begin
                errors++;
                $display("FAIL map_par_%h got=%b exp=%b", sels[k], parity_o, exp_e[35:32]);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  s;
        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            s = 8'($urandom);
            drive(1'b1, d, s);
            pop_exp();
            checks++;
            if (valid_o !== 1'b1 || value_o !== exp_e[31:0]) begin
                errors++;
                $display("FAIL b2b_%0d got=%b/%h exp=1/%h", k, valid_o, value_o, exp_e[31:0]);
            end
`ifdef ALIGN_PARITY_EN
            checks++;
            if (parity_o !== exp_e[35:32]) begin
                errors++;
                $display("FAIL b2b_par_%0d got=%b exp=%b", k, parity_o, exp_e[35:32]);
            end
`endif
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, $urandom, 8'($urandom));
            checks++;
            if (valid_o !== 1'b0 || value_o !== last_e[31:0]) begin
                errors++;
                $display("FAIL hold_%0d got=%b/%h exp=0/%h", k, valid_o, value_o, last_e[31:0]);
            end
`ifdef ALIGN_PARITY_EN
            checks++;
            if (parity_o !== last_e[35:32]) begin
                errors++;
                $display("FAIL hold_par_%0d got=%b exp=%b", k, parity_o, last_e[35:32]);
            end
`endif
        end
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL b2b_leftover got=%0d exp=0", q.size());
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'hA5C3_0FF0, 8'h1B);
        pop_exp();
        checks++;
        if (valid_o !== 1'b1 || value_o !== 32'hF00FC3A5) begin
            errors++; $display("FAIL arst_pre got=%b/%h exp=1/f00fc3a5", valid_o, value_o);
        end
        // assert reset well between edges, with a beat presented that must be dropped
        #2 rst = 1'b1;
        value_i = 32'hDEADBEEF; sel = 8'hE4;
        #1;
        checks++;
        if (valid_o !== 1'b0 || value_o !== 32'h0) begin
            errors++; $display("FAIL arst_now got=%b/%h exp=0/00000000", valid_o, value_o);
        end
`ifdef ALIGN_PARITY_EN
        checks++;
        if (parity_o !== 4'b0) begin
            errors++; $display("FAIL arst_par got=%b exp=0000", parity_o);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b0 || value_o !== 32'h0) begin
            errors++; $display("FAIL arst_drop got=%b/%h exp=0/00000000", valid_o, value_o);
        end
        #3 rst = 1'b0;
        valid_i = 1'b0;
        q.delete();
        drive(1'b0, 32'h0, 8'h00);
        checks++;
        if (valid_o !== 1'b0 || value_o !== 32'h0) begin
            errors++; $display("FAIL arst_post got=%b/%h exp=0/00000000", valid_o, value_o);
        end
        drive(1'b1, 32'hCAFEF00D, 8'h00);
        pop_exp();
        checks++;
        if (valid_o !== 1'b1 || value_o !== 32'h0D0D0D0D) begin
            errors++; $display("FAIL arst_resume got=%b/%h exp=1/0d0d0d0d", valid_o, value_o);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_mapping();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
